decoder_nx2n_seq: RTL and testbench

Registered, parametrised binary-to-one-hot decoder with valid/ready input handshake, output enable and an optional self-timed scan mode. It generalises the fixed 3-to-8 dataflow decoder to SEL_W-to-2^SEL_W. Outputs are registered, so it can drive select lines, LED/row strobes or chip-selects directly in the synchronous datapath.

---
 rtl/decoder_nx2n_seq.sv | 116 +++++++++++
 tb/tb_decoder_nx2n_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_nx2n_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with valid/ready input and output enable.
// Define DECODER_SCAN_EN to add the self-timed scan mode (SCAN state, dwell counter, scan_start).
module decoder_nx2n_seq #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    scan_start,
  output logic                    scan_busy,
  output logic [(1<<SEL_W)-1:0]   q,
  output logic                    q_valid,
  output logic [SEL_W-1:0]        idx
);

  localparam int OUT_W = 1 << SEL_W;

`ifdef DECODER_SCAN_EN
  // state | meaning
  // IDLE  | decode accepted sel values; q holds last decode or zero
  // SCAN  | walk q over every output, DWELL cycles each, then return to IDLE
  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;

  assign in_ready = en & (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= '0;
      q_valid   <= 1'b0;
      idx       <= '0;
      scan_busy <= 1'b0;
      dwell_cnt <= '0;
    end else if (!en) begin
      state     <= IDLE;
      q         <= '0;
      q_valid   <= 1'b0;
      scan_busy <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // scan_start wins a collision; the sel transfer is consumed and dropped
          if (scan_start) begin
            state     <= SCAN;
            scan_busy <= 1'b1;
            q         <= OUT_W'(1);
            idx       <= '0;
            q_valid   <= 1'b1;
            dwell_cnt <= '0;
          end else if (in_valid && in_ready) begin
            q       <= OUT_W'(1) << sel;
            idx     <= sel;
            q_valid <= 1'b1;
          end
        end
        SCAN: begin
          if (dwell_cnt == CNT_W'(DWELL - 1)) begin
            dwell_cnt <= '0;
            if (idx == SEL_W'(OUT_W - 1)) begin
              state     <= IDLE;
              scan_busy <= 1'b0;
              q         <= '0;
              q_valid   <= 1'b0;
            end else begin
              idx <= idx + SEL_W'(1);
              q   <= q << 1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          scan_busy <= 1'b0;
          q         <= '0;
          q_valid   <= 1'b0;
        end
      endcase
    end
  end
`else
  // Scan logic absent: scan_start and DWELL are intentionally left unconnected.
  localparam int unused_dwell = DWELL;
  logic unused_scan_start;
  assign unused_scan_start = scan_start;

  assign in_ready  = en;
  assign scan_busy = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
      idx     <= '0;
    end else if (!en) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (in_valid) begin
      q       <= OUT_W'(1) << sel;
      idx     <= sel;
      q_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Directed bench for decoder_nx2n_seq: decode sweep, enable drop, async reset, width 4,
// and the scan walk/collision/abort cases when DECODER_SCAN_EN is defined.
module tb_decoder_nx2n_seq;

  logic        clk;
  logic        rst_n;
  logic        en, in_valid, scan_start;
  logic [2:0]  sel;
  logic        in_ready, scan_busy, q_valid;
  logic [7:0]  q;
  logic [2:0]  idx;

  logic        en4, in_valid4;
  logic [3:0]  sel4;
  logic        in_ready4, scan_busy4, q_valid4;
  logic [15:0] q4;
  logic [3:0]  idx4;
  logic        scan_start4;

  int n_checks;
  int n_fail;

  decoder_nx2n_seq #(.SEL_W(3), .DWELL(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .scan_start(scan_start), .scan_busy(scan_busy), .q(q),
    .q_valid(q_valid), .idx(idx)
  );

  decoder_nx2n_seq #(.SEL_W(4), .DWELL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .in_valid(in_valid4), .in_ready(in_ready4),
    .sel(sel4), .scan_start(scan_start4), .scan_busy(scan_busy4), .q(q4),
    .q_valid(q_valid4), .idx(idx4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] sweep_sel [8] = '{3'd0, 3'd6, 3'd2, 3'd5, 3'd3, 3'd4, 3'd1, 3'd7};
  logic [7:0] sweep_q   [8] = '{8'h01, 8'h40, 8'h04, 8'h20, 8'h08, 8'h10, 8'h02, 8'h80};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    en = 1'($urandom); in_valid = 1'($urandom); scan_start = 1'($urandom);
    sel = 3'($urandom);
    en4 = 1'b1; in_valid4 = 1'($urandom); sel4 = 4'($urandom); scan_start4 = 1'b0;
    tick();
    tick();
    check("rst_q", q, 8'h00);
    check("rst_q_valid", q_valid, 1'b0);
    check("rst_idx", idx, 3'd0);
    check("rst_scan_busy", scan_busy, 1'b0);
    check("rst_q4", q4, 16'h0000);

    en = 1'b1; in_valid = 1'b0; scan_start = 1'b0; sel = 3'd0;
    in_valid4 = 1'b0; sel4 = 4'd0;
    rst_n = 1'b1;
    tick();
    check("idle_q", q, 8'h00);

    // decode sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      sel = sweep_sel[i];
      in_valid = 1'b1;
      #1;
      check("sweep_in_ready", in_ready, 1'b1);
      tick();
      check($sformatf("sweep_q_%0d", i), q, sweep_q[i]);
      check("sweep_q_valid", q_valid, 1'b1);
      check("sweep_idx", idx, sweep_sel[i]);
    end
    in_valid = 1'b0;
    tick();
    check("hold_q", q, 8'h80);

    // enable drop
    sel = 3'd5; in_valid = 1'b1;
    tick();
    check("pre_drop_q", q, 8'h20);
    en = 1'b0; sel = 3'd3; in_valid = 1'b1;
    #1;
    check("drop_in_ready", in_ready, 1'b0);
    tick();
    check("drop_q", q, 8'h00);
    check("drop_q_valid", q_valid, 1'b0);
    en = 1'b1; in_valid = 1'b0;
    tick();
    check("drop_no_decode", q, 8'h00);

`ifdef DECODER_SCAN_EN
    begin
      int busy_cycles;
      // collision: scan wins, sel=5 dropped
      scan_start = 1'b1; in_valid = 1'b1; sel = 3'd5;
      #1;
      check("coll_in_ready", in_ready, 1'b1);
      tick();
      scan_start = 1'b0; in_valid = 1'b0;
      busy_cycles = scan_busy ? 1 : 0;
      check("scan_q_0", q, 8'h01);
      check("scan_busy_0", scan_busy, 1'b1);
      check("scan_in_ready", in_ready, 1'b0);
      for (int s = 1; s < 16; s++) begin
        in_valid = s[0];
        sel = 3'd3;
        tick();
        if (scan_busy) busy_cycles++;
        check($sformatf("scan_q_%0d", s), q, 8'h01 << (s / 2));
        check($sformatf("scan_idx_%0d", s), idx, 3'(s / 2));
      end
      in_valid = 1'b0;
      tick();
      if (scan_busy) busy_cycles++;
      check("scan_end_q", q, 8'h00);
      check("scan_end_busy", scan_busy, 1'b0);
      check("scan_end_q_valid", q_valid, 1'b0);
      check("scan_busy_cycles", busy_cycles, 16);

      // mid-scan enable drop
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick(); tick(); tick();
      check("abort_pre_q", q, 8'h02);
      en = 1'b0;
      tick();
      check("abort_q", q, 8'h00);
      check("abort_busy", scan_busy, 1'b0);
      en = 1'b1;
      tick();

      // mid-scan async reset
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      tick(); tick();
      check("rst_mid_pre_busy", scan_busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_q", q, 8'h00);
      check("rst_mid_busy", scan_busy, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
    end
`else
    // scan_start ignored: sel=5 decodes normally
    scan_start = 1'b1; in_valid = 1'b1; sel = 3'd5;
    #1;
    check("coll_in_ready", in_ready, 1'b1);
    tick();
    scan_start = 1'b0; in_valid = 1'b0;
    check("noscan_q", q, 8'h20);
    check("noscan_busy", scan_busy, 1'b0);
    tick();
    check("noscan_hold_q", q, 8'h20);
    rst_n = 1'b0;
    #1;
    check("rst_async_q", q, 8'h00);
    check("rst_async_q_valid", q_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    // width 4
    sel4 = 4'd15; in_valid4 = 1'b1;
    tick();
    check("w4_q_15", q4, 16'h8000);
    check("w4_idx_15", idx4, 4'd15);
    sel4 = 4'd9;
    tick();
    check("w4_q_9", q4, 16'h0200);
    check("w4_idx_9", idx4, 4'd9);
    in_valid4 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
